// File: rtl/uart_tx_queue_if.sv
// uart_tx_queue_if: host write port and transmitter launch handshake for uart_tx_queue.
//   master : host/transmitter side (drives wr_en, wr_data, txdone)
//   slave  : queue side (drives full, empty, level, start, txin, busy[, overflow])
// Optional: UART_TXQ_OVF_EN adds the sticky overflow flag.
interface uart_tx_queue_if #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              empty;
  logic [LW-1:0]     level;
  logic              start;
  logic [DATA_W-1:0] txin;
  logic              txdone;
  logic              busy;
`ifdef UART_TXQ_OVF_EN
  logic              overflow;

  modport master (
    output wr_en, wr_data, txdone,
    input  full, empty, level, start, txin, busy, overflow
  );

  modport slave (
    input  wr_en, wr_data, txdone,
    output full, empty, level, start, txin, busy, overflow
  );
`else
  modport master (
    output wr_en, wr_data, txdone,
    input  full, empty, level, start, txin, busy
  );

  modport slave (
    input  wr_en, wr_data, txdone,
    output full, empty, level, start, txin, busy
  );
`endif
endinterface

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO plus launch FSM feeding a UART transmitter. Each queued byte is
// presented on txin with a one-cycle start pulse; the next byte waits for txdone.
// Ports:
//   clk    : clock shared with the transmitter
//   rst_n  : asynchronous active-low reset, empties the queue and returns the FSM to idle
//   bus    : uart_tx_queue_if.slave (wr_en/wr_data in, full/empty/level out,
//            start/txin out, txdone in, busy out, overflow out when enabled)
// Optional: define UART_TXQ_OVF_EN for the sticky overflow flag on dropped writes.
module uart_tx_queue #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_queue_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] txin_q, txin_d;
  logic              start_q, start_d;
  logic              full, empty, push, pop;

  // Extra pointer MSB distinguishes full from empty without a wasted entry.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // full is taken from registered pointers, so a same-cycle pop never admits the write.
  assign push  = bus.wr_en && !full;

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    txin_d  = txin_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          start_d = 1'b1;
          txin_d  = mem_q[rd_ptr_q[AW-1:0]];
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus.txdone) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      start_q  <= 1'b0;
      txin_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      txin_q  <= txin_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.wr_data;
  end

  assign bus.full  = full;
  assign bus.empty = empty;
  assign bus.level = wr_ptr_q - rd_ptr_q;
  assign bus.start = start_q;
  assign bus.txin  = txin_q;
  assign bus.busy  = (state_q == StWait);

`ifdef UART_TXQ_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (bus.wr_en && full) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.overflow = ovf_q;
`endif

endmodule
